data_mem_responder: RTL and testbench

//  Memory-side responder for the processor's data-memory port (CEN/WEN/OEN, A, Data2Mem, ReadDataMem).

---
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for a single-cycle processor port (CEN/WEN/OEN,
// active-low), with a post-reset clearing sweep and a valid/ready side loader.
//
// Loader handshake: a word is written when ld_valid and ld_ready are both
// high at a rising clock edge. ld_ready is combinational from the current
// state and the processor strobes, so the loader must hold ld_addr/ld_data
// stable until it sees the transfer complete. A processor store owns the
// single write port and stalls the loader for that cycle.
module data_mem_responder #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          busy,
  output logic          err,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt
);

  localparam int DEPTH = 1 << AW;

  // Two-state controller; busy is the registered decode of ST_INIT and
  // serves as the externally visible state.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          is_idle;
  logic          proc_acc;
  logic          conflict;
  logic          rd_en;
  logic          wr_en;
  logic          ld_fire;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Decode processor strobes and loader handshake for the current cycle.
  always_comb begin
    is_idle  = (state_q == ST_IDLE);
    proc_acc = ~CEN & (~WEN | ~OEN);
    conflict = ~CEN & ~WEN & ~OEN;
    rd_en    = is_idle & ~CEN & ~OEN & WEN;
    wr_en    = is_idle & ~CEN & ~WEN & OEN;
    ld_ready = is_idle & ~(~CEN & ~WEN);
    ld_fire  = ld_valid & ld_ready;
  end

  // Single write port: sweep clear, else processor store, else loader.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
      end else if (wr_en) begin
        mem_we    = 1'b1;
        mem_waddr = A;
        mem_wdata = D;
      end else if (ld_fire) begin
        mem_we    = 1'b1;
      end
    end
  end

  // Storage array; contents are cleared by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Load data is combinational so the processor sees it in the same cycle;
  // a same-cycle loader write to A is not forwarded.
  always_comb begin
    Q = rd_en ? mem_q[A] : '0;
  end

  // Next-state logic for the controller, error flag and saturating counters.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;

    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + AW'(1);
      if (&ptr_q) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end

    if (conflict || (busy_q && proc_acc)) begin
      err_d = 1'b1;
    end

    if (rd_en && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (wr_en && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  // Controller state and status registers; reset restarts the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign busy   = busy_q;
  assign err    = err_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: reset sweep, store/load, error
// cases, loader handshake, reset mid-sweep and counter saturation.
module tb_data_mem_responder;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          CEN;
  logic          WEN;
  logic          OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          busy;
  logic          err;
  logic [15:0]   rd_cnt;
  logic [15:0]   wr_cnt;

  int tests_run;
  int tests_failed;

  data_mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(Q),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; D = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic drive_read(input logic [AW-1:0] addr);
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = addr;
  endtask

  task automatic drive_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = addr; D = data;
  endtask

  task automatic reset_and_sweep();
    int n;
    drive_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    int n;
    drive_idle();
    rst = 1'b1;
    ld_valid = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_busy: got %b want 1", busy); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", err); end
    tests_run++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL rst_cnt: rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
    end
    tests_run++;
    if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
    tests_run++;
    if (Q !== 32'h0) begin tests_failed++; $display("FAIL rst_q: got %h want 0", Q); end
    ld_valid = 1'b0;
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != 128) begin tests_failed++; $display("FAIL sweep_len: busy cycles %0d want 128", n); end
    for (int a = 0; a < 128; a++) begin
      drive_read(AW'(a));
      #1;
      tests_run++;
      if (Q !== 32'h0) begin tests_failed++; $display("FAIL clear_read: addr %0d got %h want 0", a, Q); end
      tick();
    end
    drive_idle();
    tests_run++;
    if (rd_cnt !== 16'd128) begin tests_failed++; $display("FAIL clear_rd_cnt: got %0d want 128", rd_cnt); end
  endtask

  task automatic test_store_load();
    reset_and_sweep();
    drive_write(7'h05, 32'hDEADBEEF);
    #1;
    tests_run++;
    if (Q !== 32'h0) begin tests_failed++; $display("FAIL store_q: got %h want 0", Q); end
    tests_run++;
    if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL store_ld_ready: got %b want 0", ld_ready); end
    tick();
    drive_read(7'h05);
    #1;
    tests_run++;
    if (Q !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_q: got %h want deadbeef", Q); end
    tick();
    drive_idle();
    tests_run++;
    if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL store_load_cnt: rd=%0d wr=%0d want 1 1", rd_cnt, wr_cnt);
    end
    drive_read(7'h06);
    #1;
    tests_run++;
    if (Q !== 32'h0) begin tests_failed++; $display("FAIL other_addr: got %h want 0", Q); end
    tick();
    drive_idle();
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL store_err: got %b want 0", err); end
  endtask

  task automatic test_conflict();
    reset_and_sweep();
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b0; A = 7'h03; D = 32'h1;
    #1;
    tests_run++;
    if (Q !== 32'h0) begin tests_failed++; $display("FAIL conflict_q: got %h want 0", Q); end
    tick();
    drive_idle();
    tick(); tick();
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL conflict_err: got %b want 1", err); end
    tests_run++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL conflict_cnt: rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
    end
    drive_read(7'h03);
    #1;
    tests_run++;
    if (Q !== 32'h0) begin tests_failed++; $display("FAIL conflict_mem: got %h want 0", Q); end
    tick();
    drive_idle();
  endtask

  task automatic test_loader();
    reset_and_sweep();
    ld_valid = 1'b1; ld_addr = 7'h09; ld_data = 32'h1234;
    drive_write(7'h02, 32'h000000AA);
    #1;
    tests_run++;
    if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL ld_blocked: got %b want 0", ld_ready); end
    tick();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
    #1;
    tests_run++;
    if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL ld_accept: got %b want 1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    drive_read(7'h09);
    #1;
    tests_run++;
    if (Q !== 32'h1234) begin tests_failed++; $display("FAIL ld_mem9: got %h want 1234", Q); end
    tick();
    drive_read(7'h02);
    #1;
    tests_run++;
    if (Q !== 32'hAA) begin tests_failed++; $display("FAIL ld_mem2: got %h want aa", Q); end
    tick();
    // Loader write and processor read to the same word in one cycle.
    ld_valid = 1'b1; ld_addr = 7'h09; ld_data = 32'h5678;
    drive_read(7'h09);
    #1;
    tests_run++;
    if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL ld_ready_rd: got %b want 1", ld_ready); end
    tests_run++;
    if (Q !== 32'h1234) begin tests_failed++; $display("FAIL ld_rd_old: got %h want 1234", Q); end
    tick();
    ld_valid = 1'b0;
    #1;
    tests_run++;
    if (Q !== 32'h5678) begin tests_failed++; $display("FAIL ld_rd_new: got %h want 5678", Q); end
    tick();
    drive_idle();
    tests_run++;
    if (wr_cnt !== 16'd1) begin tests_failed++; $display("FAIL ld_wr_cnt: got %0d want 1", wr_cnt); end
    tests_run++;
    if (rd_cnt !== 16'd4) begin tests_failed++; $display("FAIL ld_rd_cnt: got %0d want 4", rd_cnt); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) begin
        drive_read(7'h01);
        #1;
        tests_run++;
        if (Q !== 32'h0) begin tests_failed++; $display("FAIL busy_read_q: got %h want 0", Q); end
      end
      tick();
      if (c == 10) begin
        drive_idle();
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL busy_access_err: got %b want 1", err); end
      end
    end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      tests_failed++; $display("FAIL mid_rst: busy=%b err=%b want 1 0", busy, err);
    end
    tick();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != 128) begin tests_failed++; $display("FAIL mid_sweep_len: busy cycles %0d want 128", n); end
  endtask

  task automatic test_saturation();
    reset_and_sweep();
    drive_read(7'h00);
    for (int c = 0; c < 65534; c++) tick();
    tests_run++;
    if (rd_cnt !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_pre: got %h want fffe", rd_cnt); end
    tick();
    tests_run++;
    if (rd_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hit: got %h want ffff", rd_cnt); end
    for (int c = 0; c < 70000 - 65535; c++) tick();
    drive_idle();
    tests_run++;
    if (rd_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold: got %h want ffff", rd_cnt); end
    tests_run++;
    if (wr_cnt !== 16'd0) begin tests_failed++; $display("FAIL sat_wr_cnt: got %0d want 0", wr_cnt); end
  endtask

  // Sequence and final report
  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_store_load();
    test_conflict();
    test_loader();
    test_reset_mid_sweep();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
